// File: rtl/ps2_codes_pkg.sv
// ps2_codes_pkg: scancode constants, prefix FSM states and key classes shared by the digit-entry path
package ps2_codes_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_e;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_BS,
    KEY_ESC,
    KEY_ENTER
  } key_e;

endpackage

// File: rtl/ps2_key_classify.sv
// ps2_key_classify: maps a make code to a key class and, for digit keys, its BCD value
module ps2_key_classify
  import ps2_codes_pkg::*;
(
  input  logic [7:0] code_i,
  output key_e       key_o,
  output logic [3:0] digit_o
);

  // main-row and keypad digits share one table; editing keys follow; everything else is ignored
  always_comb begin
    key_o   = KEY_DIGIT;
    digit_o = 4'd0;
    case (code_i)
      8'h45, 8'h70: digit_o = 4'd0;
      8'h16, 8'h69: digit_o = 4'd1;
      8'h1E, 8'h72: digit_o = 4'd2;
      8'h26, 8'h7A: digit_o = 4'd3;
      8'h25, 8'h6B: digit_o = 4'd4;
      8'h2E, 8'h73: digit_o = 4'd5;
      8'h36, 8'h74: digit_o = 4'd6;
      8'h3D, 8'h6C: digit_o = 4'd7;
      8'h3E, 8'h75: digit_o = 4'd8;
      8'h46, 8'h7D: digit_o = 4'd9;
      SC_BKSP:      key_o   = KEY_BS;
      SC_ESC:       key_o   = KEY_ESC;
      SC_ENTER:     key_o   = KEY_ENTER;
      default:      key_o   = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_digit_entry.sv
// ps2_digit_entry: PS/2 scancode stream to right-aligned BCD entry with backspace, clear and commit
module ps2_digit_entry
  import ps2_codes_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            code_i,
  input  logic                  code_valid_i,
  output logic [4*DIGITS-1:0]   entry_o,
  output logic [2:0]            count_o,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  value_valid_o,
  output logic                  overflow_o
);

  localparam int W = 4 * DIGITS;

  state_e         state_q;
  logic [W-1:0]   entry_q;
  logic [W-1:0]   value_q;
  logic [2:0]     count_q;
  logic           vv_q;
  logic           ovf_q;
  key_e           cls;
  key_e           act;
  logic [3:0]     digit;

  ps2_key_classify u_classify (
    .code_i  (code_i),
    .key_o   (cls),
    .digit_o (digit)
  );

  // only bare make codes in IDLE and keypad Enter after E0 carry an action; prefixes and breaks do nothing
  always_comb begin
    act = KEY_NONE;
    if (code_valid_i && state_q == ST_IDLE && code_i != SC_BREAK && code_i != SC_EXT)
      act = cls;
    else if (code_valid_i && state_q == ST_EXT && code_i == SC_ENTER)
      act = KEY_ENTER;
  end

  // prefix FSM plus the accumulator and commit registers, all advanced by the same accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      value_q <= '0;
      count_q <= '0;
      vv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vv_q <= 1'b0;
      if (code_valid_i)
        case (state_q)
          ST_IDLE: state_q <= code_i == SC_BREAK ? ST_BRK : code_i == SC_EXT ? ST_EXT : ST_IDLE;
          ST_EXT:  state_q <= code_i == SC_BREAK ? ST_EXT_BRK : ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      case (act)
        KEY_DIGIT: begin
          if (count_q < 3'(DIGITS)) begin
            entry_q <= {entry_q[W-5:0], digit};
            count_q <= count_q + 3'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        KEY_BS: begin
          if (count_q != 3'd0) begin
            entry_q <= {4'h0, entry_q[W-1:4]};
            count_q <= count_q - 3'd1;
          end
          ovf_q <= 1'b0;
        end
        KEY_ESC: begin
          entry_q <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
        KEY_ENTER: begin
          value_q <= entry_q;
          vv_q    <= 1'b1;
          entry_q <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign entry_o       = entry_q;
  assign count_o       = count_q;
  assign value_o       = value_q;
  assign value_valid_o = vv_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// tb_ps2_digit_entry: directed scenario tests for the PS/2 digit-entry block
module tb_ps2_digit_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  code = 8'h00;
  logic        valid = 1'b0;
  logic [15:0] entry;
  logic [2:0]  count;
  logic [15:0] value;
  logic        vv;
  logic        ovf;
  int          checks = 0;
  int          failures = 0;

  ps2_digit_entry #(.DIGITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_i        (code),
    .code_valid_i  (valid),
    .entry_o       (entry),
    .count_o       (count),
    .value_o       (value),
    .value_valid_o (vv),
    .overflow_o    (ovf)
  );

  always #5 clk = ~clk;

  // drive one byte for a single cycle; returns at the next falling edge, where its effect is visible
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    code = c;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [15:0] e, input logic [2:0] c,
                              input logic [15:0] v, input logic p, input logic o);
    checks++;
    if ({entry, count, value, vv, ovf} !== {e, c, v, p, o}) begin
      failures++;
      $display("FAIL %s: got entry=%h count=%0d value=%h vv=%b ovf=%b, expected entry=%h count=%0d value=%h vv=%b ovf=%b",
               name, entry, count, value, vv, ovf, e, c, v, p, o);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    code = 8'h16;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({entry, count, value, vv, ovf} !== '0) begin
      failures++;
      $display("FAIL reset: got entry=%h count=%0d value=%h vv=%b ovf=%b, expected all zero", entry, count, value, vv, ovf);
    end
    valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_main_row;
    send(8'h16); send(8'hF0); send(8'h16);
    expect_state("main_first", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0);
    send(8'h1E); send(8'hF0); send(8'h1E);
    expect_state("main_two", 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0);
    send(8'h5A);
    expect_state("main_enter", 16'h0000, 3'd0, 16'h0012, 1'b1, 1'b0);
    @(negedge clk);
    expect_state("main_pulse_end", 16'h0000, 3'd0, 16'h0012, 1'b0, 1'b0);
  endtask

  task automatic test_keypad_overflow;
    send(8'h69); send(8'h72); send(8'h7A); send(8'h6B);
    expect_state("kp_full", 16'h1234, 3'd4, 16'h0012, 1'b0, 1'b0);
    send(8'h73);
    expect_state("kp_overflow", 16'h1234, 3'd4, 16'h0012, 1'b0, 1'b1);
    send(8'h66);
    expect_state("kp_backspace", 16'h0123, 3'd3, 16'h0012, 1'b0, 1'b0);
  endtask

  task automatic test_ext_enter;
    send(8'hE0);
    expect_state("ext_prefix", 16'h0123, 3'd3, 16'h0012, 1'b0, 1'b0);
    send(8'h5A);
    expect_state("ext_enter", 16'h0000, 3'd0, 16'h0123, 1'b1, 1'b0);
    send(8'h16);
    send(8'hE0); send(8'hF0); send(8'h5A);
    expect_state("ext_break_enter", 16'h0001, 3'd1, 16'h0123, 1'b0, 1'b0);
    send(8'h1E);
    expect_state("ext_back_idle", 16'h0012, 3'd2, 16'h0123, 1'b0, 1'b0);
  endtask

  task automatic test_esc;
    send(8'h76);
    send(8'h45); send(8'h45); send(8'h3D);
    expect_state("esc_leading_zero", 16'h0007, 3'd3, 16'h0123, 1'b0, 1'b0);
    send(8'h76);
    expect_state("esc_clear", 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0);
    send(8'h66);
    expect_state("bs_empty", 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0);
    send(8'h12);
    expect_state("ignored_code", 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0);
  endtask

  task automatic test_enter_empty;
    send(8'h5A);
    expect_state("enter_empty", 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    code = 8'h16; valid = 1'b1;
    @(negedge clk);
    expect_state("b2b_first", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0);
    code = 8'h1E;
    @(negedge clk);
    code = 8'h26;
    @(negedge clk);
    valid = 1'b0;
    expect_state("b2b_three", 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    send(8'hF0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({entry, count, value, vv, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_async: got entry=%h count=%0d value=%h vv=%b ovf=%b, expected all zero", entry, count, value, vv, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h16);
    expect_state("reset_drops_break", 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_main_row;
    test_keypad_overflow;
    test_ext_enter;
    test_esc;
    test_enter_empty;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_digit_entry.md
# ps2_digit_entry

Consumes the byte stream from the PS/2 keyboard receiver and turns it into a decimal entry. Tracks make/break/extended prefixes, maps digit keys (main row and keypad) to BCD, and supports Backspace, Esc (clear) and Enter (commit) editing. Sits between the PS/2 keyboard receiver and the number register / seven-segment display path. Delivers a live BCD entry plus a committed value with a one-cycle strobe.

## Interface
- DIGITS, 4: number of BCD digits held; entry width is 4*DIGITS.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- code_in  in  8  scancode byte from the keyboard receiver.
- code_valid  in  1  one-cycle strobe; code_in is valid in that cycle.
- entry  out  4*DIGITS  live BCD entry, right-aligned, least-significant digit in [3:0].
- count  out  3  number of digits currently entered, 0..DIGITS.
- value  out  4*DIGITS  last committed entry.
- value_valid  out  1  one-cycle pulse when value updates.
- overflow  out  1  sticky; a digit was rejected because the entry was full.

## Operation
- Prefix FSM with states IDLE, BRK, EXT and EXT_BRK; it advances only on code_valid.
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code and is acted on; stay in IDLE.
  - BRK: any byte is discarded -> IDLE.
  - EXT: F0 -> EXT_BRK; 5A (keypad Enter) acts as Enter -> IDLE; any other byte is discarded -> IDLE.
  - EXT_BRK: any byte is discarded -> IDLE.
- Make-code map:
  - Main-row digits 0-9: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46.
  - Keypad digits 0-9: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D.
  - 66 = Backspace; 76 = Esc; 5A = Enter. All other codes are ignored.
- Typematic repeats (make code again without a break) count as new keystrokes.
- Digit d:
  - If count < DIGITS: entry <= {entry shifted left 4, d}; count+1.
  - Otherwise: entry is unchanged and overflow <= 1.
- Backspace: if count > 0, entry is shifted right 4 with zero fill and count-1; otherwise no-op. Clears overflow.
- Esc: entry <= 0, count <= 0, overflow <= 0.
- Enter: value <= entry, value_valid pulses, entry <= 0, count <= 0, overflow <= 0.
  - Enter with count = 0 still commits 0 and pulses.
- Leading zeros are real digits: "0","0","7" gives count 3 and entry 0x0007.

## Timing
- Every effect is registered. A code accepted in cycle N is visible on the outputs in cycle N+1.
- value_valid is high in cycle N+1 only.
- code_valid may be asserted on consecutive cycles; each byte is processed, and none is dropped.
- code_valid is ignored while reset is asserted.
- Reset values: entry 0, count 0, value 0, value_valid 0, overflow 0, FSM IDLE.
- Reset asserted mid-sequence (for example after F0) forces IDLE. The next byte is then treated as a make code.
- Prefix bytes never alter entry, value or overflow.
- All arithmetic is shift-only; there is no binary conversion. Consumers handle BCD.

## Structure
- Shared package ps2_codes_pkg holds:
  - the scancode constants (F0, E0, 5A, 66, 76);
  - the FSM state enum;
  - the key-class enum (KEY_DIGIT, KEY_BS, KEY_ESC, KEY_ENTER, KEY_NONE).
- Sub-module ps2_key_classify: combinational, code_in -> {key class, 4-bit digit}. It is instantiated once.
- The top holds the prefix FSM and the accumulator/commit registers.

## Test plan
- Reset, then bytes 16, F0, 16, 1E, F0, 1E, 5A -> entry ends 0x0012 before Enter. On Enter: value 0x0012 with a single value_valid pulse, then entry 0, count 0.
- Keypad 69, 72, 7A, 6B, 73 with no breaks -> entry 0x1234, count 4, overflow 1. Then Backspace 66 -> entry 0x0123, count 3, overflow 0.
- Byte sequence E0, 5A -> commits the current entry (keypad Enter). Byte sequence E0, F0, 5A -> no commit and no state change.
- Digits 45, 45, 3D then Esc 76 -> entry 0, count 0, value unchanged, value_valid stays low. Backspace with count 0 -> no change.
- Back-to-back code_valid on every cycle for 16, 1E, 26 -> entry 0x0123 three cycles after the first strobe.
- Send F0, then assert reset, release it, send 16 -> entry 0x0001, showing the pending break was dropped. Also check every output is 0 while reset is low.
